// File: rtl/shiftreg_pkg.sv
// Shared types for the universal shift register: operation encoding and
// the width helper for the frame counter.
package shiftreg_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_SHR  = 2'b01,
    MODE_SHL  = 2'b10,
    MODE_LOAD = 2'b11
  } mode_t;

  // Bits needed to hold a shift count of 0..width
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/shift_frame_cnt.sv
// Frame counter: counts shift edges, wraps at WIDTH and emits a one-cycle
// registered frame_done pulse on the wrapping edge.
module shift_frame_cnt
  import shiftreg_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                           clock,
  input  logic                           clear,
  input  logic                           load,
  input  logic                           shift,
  output logic [cnt_width(WIDTH)-1:0]    cnt,
  output logic                           frame_done
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [CW-1:0] cnt_reg;
  logic [CW-1:0] cnt_next;
  logic          done_reg;
  logic          done_next;

  // done_next defaults low so the pulse drops on every edge, enabled or not
  always_comb begin
    cnt_next  = cnt_reg;
    done_next = 1'b0;
    if (load) begin
      cnt_next = '0;
    end else if (shift) begin
      if (cnt_reg == LAST) begin
        cnt_next  = '0;
        done_next = 1'b1;
      end else begin
        cnt_next = cnt_reg + CW'(1);
      end
    end
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      cnt_reg  <= '0;
      done_reg <= 1'b0;
    end else begin
      cnt_reg  <= cnt_next;
      done_reg <= done_next;
    end
  end

  assign cnt        = cnt_reg;
  assign frame_done = done_reg;

endmodule

// File: rtl/shiftreg_univ.sv
// Universal shift register with hold / shift right / shift left / load and
// a frame counter. Optional rotate input enabled by SHIFTREG_ROTATE_EN.
module shiftreg_univ
  import shiftreg_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                           clock,
  input  logic                           clear,
  input  logic                           en,
  input  logic [1:0]                     mode,
  input  logic                           sin_r,
  input  logic                           sin_l,
  input  logic [WIDTH-1:0]               pdata,
`ifdef SHIFTREG_ROTATE_EN
  input  logic                           rot,
`endif
  output logic [WIDTH-1:0]               q,
  output logic                           sout_r,
  output logic                           sout_l,
  output logic [cnt_width(WIDTH)-1:0]    cnt,
  output logic                           frame_done
);

  mode_t            op;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] shr_val;
  logic [WIDTH-1:0] shl_val;
  logic             fill_r;
  logic             fill_l;
  logic             is_shift;
  logic             is_load;

  assign op = mode_t'(mode);

`ifdef SHIFTREG_ROTATE_EN
  // Rotation feeds the bit leaving one end back into the other end
  assign fill_r = rot ? q_reg[0]       : sin_r;
  assign fill_l = rot ? q_reg[WIDTH-1] : sin_l;
`else
  assign fill_r = sin_r;
  assign fill_l = sin_l;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      if (gi == WIDTH - 1) begin : g_top
        assign shr_val[gi] = fill_r;
      end else begin : g_mid_r
        assign shr_val[gi] = q_reg[gi+1];
      end
      if (gi == 0) begin : g_bot
        assign shl_val[gi] = fill_l;
      end else begin : g_mid_l
        assign shl_val[gi] = q_reg[gi-1];
      end
    end
  endgenerate

  always_comb begin
    q_next = q_reg;
    if (en) begin
      case (op)
        MODE_SHR:  q_next = shr_val;
        MODE_SHL:  q_next = shl_val;
        MODE_LOAD: q_next = pdata;
        default:   q_next = q_reg;
      endcase
    end
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      q_reg <= '0;
    end else begin
      q_reg <= q_next;
    end
  end

  assign is_shift = en && ((op == MODE_SHR) || (op == MODE_SHL));
  assign is_load  = en && (op == MODE_LOAD);

  shift_frame_cnt #(
    .WIDTH (WIDTH)
  ) u_frame_cnt (
    .clock      (clock),
    .clear      (clear),
    .load       (is_load),
    .shift      (is_shift),
    .cnt        (cnt),
    .frame_done (frame_done)
  );

  assign q      = q_reg;
  assign sout_r = q_reg[0];
  assign sout_l = q_reg[WIDTH-1];

endmodule

// File: tb/tb_shiftreg_univ.sv
// Self-checking bench for shiftreg_univ (WIDTH=4): directed scenarios plus
// randomized traffic against an arithmetic reference model.
module tb_shiftreg_univ;

  localparam int W  = 4;
  localparam int CW = $clog2(W + 1);

  logic          clock = 1'b0;
  logic          clear;
  logic          en;
  logic [1:0]    mode;
  logic          sin_r;
  logic          sin_l;
  logic [W-1:0]  pdata;
  logic          rot = 1'b0;
  logic [W-1:0]  q;
  logic          sout_r;
  logic          sout_l;
  logic [CW-1:0] cnt;
  logic          frame_done;

  int errors = 0;
  int checks = 0;

  // Reference model state
  int m_q;
  int m_cnt;
  int m_done;

  always #5 clock = ~clock;

  shiftreg_univ #(.WIDTH(W)) dut (
    .clock      (clock),
    .clear      (clear),
    .en         (en),
    .mode       (mode),
    .sin_r      (sin_r),
    .sin_l      (sin_l),
    .pdata      (pdata),
`ifdef SHIFTREG_ROTATE_EN
    .rot        (rot),
`endif
    .q          (q),
    .sout_r     (sout_r),
    .sout_l     (sout_l),
    .cnt        (cnt),
    .frame_done (frame_done)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q = 0;
    m_cnt = 0;
    m_done = 0;
  endtask

  task automatic model_count();
    m_cnt = m_cnt + 1;
    if (m_cnt == W) begin
      m_cnt = 0;
      m_done = 1;
    end
  endtask

  // Applies one rising edge worth of behaviour from the current inputs
  task automatic model_edge();
    int fill;
    int use_rot;
    use_rot = 0;
`ifdef SHIFTREG_ROTATE_EN
    use_rot = int'(rot);
`endif
    m_done = 0;
    if (en) begin
      case (mode)
        2'd1: begin
          fill = use_rot ? (m_q % 2) : int'(sin_r);
          m_q = (m_q / 2) + fill * (1 << (W - 1));
          model_count();
        end
        2'd2: begin
          fill = use_rot ? (m_q / (1 << (W - 1))) : int'(sin_l);
          m_q = (m_q * 2 + fill) % (1 << W);
          model_count();
        end
        2'd3: begin
          m_q = int'(pdata);
          m_cnt = 0;
        end
        default: ;
      endcase
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".q"}, 64'(q), 64'(m_q));
    check({tag, ".cnt"}, 64'(cnt), 64'(m_cnt));
    check({tag, ".frame_done"}, 64'(frame_done), 64'(m_done));
    check({tag, ".sout_r"}, 64'(sout_r), 64'(m_q % 2));
    check({tag, ".sout_l"}, 64'(sout_l), 64'(m_q / (1 << (W - 1))));
  endtask

  task automatic do_cycle(input string tag, input logic e, input logic [1:0] md,
                          input logic sr, input logic sl, input logic [W-1:0] pd);
    en = e;
    mode = md;
    sin_r = sr;
    sin_l = sl;
    pdata = pd;
    @(posedge clock);
    #1;
    model_edge();
    check_all(tag);
    $display("%s en=%0b mode=%0d sr=%0b sl=%0b pd=%b -> q=%b cnt=%0d done=%0b",
             tag, e, md, sr, sl, pd, q, cnt, frame_done);
  endtask

  // Asserts clear between edges and checks the immediate (asynchronous) effect
  task automatic mid_clear(input string tag);
    #2 clear = 1'b1;
    #1;
    model_reset();
    check_all(tag);
    $display("%s clear mid-cycle -> q=%b cnt=%0d done=%0b", tag, q, cnt, frame_done);
    #1 clear = 1'b0;
  endtask

  initial begin
    logic [3:0] stream;
    clear = 1'b1;
    en = 1'b1;
    mode = 2'd3;
    sin_r = 1'b0;
    sin_l = 1'b0;
    pdata = 4'b1011;
    model_reset();

    // Reset holds everything at zero even across an enabled load edge
    #3;
    check_all("reset_async");
    @(posedge clock);
    #1;
    check_all("reset_edge");
    #2 clear = 1'b0;

    // Load straight after release
    do_cycle("load_1011", 1'b1, 2'd3, 1'b0, 1'b0, 4'b1011);
    check("load_1011.q_const", 64'(q), 64'hB);
    check("load_1011.cnt_const", 64'(cnt), 64'h0);

    // Serial right shift of 1,0,1,1 from zero
    do_cycle("load_0000", 1'b1, 2'd3, 1'b0, 1'b0, 4'b0000);
    stream = 4'b1101;
    for (int i = 0; i < 4; i++) begin
      do_cycle("shr_stream", 1'b1, 2'd1, stream[i], 1'b0, 4'b0000);
      check("shr_stream.cnt_const", 64'(cnt), 64'((i + 1) % 4));
      check("shr_stream.done_const", 64'(frame_done), 64'(i == 3));
    end
    check("shr_stream.q_const", 64'(q), 64'hD);
    do_cycle("after_frame", 1'b1, 2'd0, 1'b0, 1'b0, 4'b0000);
    check("after_frame.done_const", 64'(frame_done), 64'h0);

    // Left shift out of the MSB
    do_cycle("load_1000", 1'b1, 2'd3, 1'b0, 1'b0, 4'b1000);
    check("load_1000.sout_l_const", 64'(sout_l), 64'h1);
    do_cycle("shl_one", 1'b1, 2'd2, 1'b0, 1'b0, 4'b0000);
    check("shl_one.q_const", 64'(q), 64'h0);
    check("shl_one.cnt_const", 64'(cnt), 64'h1);

    // Enable stall and direction change
    do_cycle("load_0110", 1'b1, 2'd3, 1'b0, 1'b0, 4'b0110);
    do_cycle("mix_shr", 1'b1, 2'd1, 1'b1, 1'b0, 4'b0000);
    for (int i = 0; i < 3; i++) begin
      do_cycle("mix_stall", 1'b0, 2'(i + 1), 1'b1, 1'b1, 4'b1111);
      check("mix_stall.cnt_const", 64'(cnt), 64'h1);
    end
    do_cycle("mix_shl", 1'b1, 2'd2, 1'b0, 1'b1, 4'b0000);
    check("mix_shl.cnt_const", 64'(cnt), 64'h2);
    do_cycle("mix_shl", 1'b1, 2'd2, 1'b0, 1'b0, 4'b0000);
    check("mix_shl.cnt_const2", 64'(cnt), 64'h3);
    check("mix_shl.done_const", 64'(frame_done), 64'h0);

    // Clear in the middle of a frame
    do_cycle("load_0101", 1'b1, 2'd3, 1'b0, 1'b0, 4'b0101);
    do_cycle("pre_clear", 1'b1, 2'd1, 1'b1, 1'b0, 4'b0000);
    do_cycle("pre_clear", 1'b1, 2'd2, 1'b0, 1'b1, 4'b0000);
    mid_clear("mid_clear");
    do_cycle("post_clear", 1'b1, 2'd1, 1'b1, 1'b0, 4'b0000);
    check("post_clear.cnt_const", 64'(cnt), 64'h1);

`ifdef SHIFTREG_ROTATE_EN
    // Rotation right through a full frame
    do_cycle("rot_load", 1'b1, 2'd3, 1'b0, 1'b0, 4'b0001);
    rot = 1'b1;
    for (int i = 0; i < 4; i++) begin
      do_cycle("rot_shr", 1'b1, 2'd1, 1'b0, 1'b0, 4'b0000);
      check("rot_shr.q_const", 64'(q), 64'(4'b1000 >> i));
      check("rot_shr.done_const", 64'(frame_done), 64'(i == 3));
    end
    rot = 1'b0;
`endif

    // Randomized traffic, with occasional asynchronous clears
    for (int n = 0; n < 400; n++) begin
`ifdef SHIFTREG_ROTATE_EN
      rot = 1'($urandom_range(0, 1));
`endif
      do_cycle("rand", 1'($urandom_range(0, 4) != 0), 2'($urandom_range(0, 3)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom));
      if ($urandom_range(0, 39) == 0) begin
        mid_clear("rand_clear");
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
